mem_bist: RTL and testbench
===========================

# mem_bist

Built-in self-test controller for the `mem` block: the initiator end of the memory write/read interface. On `start` it runs a four-phase pattern sequence against the memory, checks every read-back against internally computed expected data, and reports pass/fail with the first failing address and data. It sits between the top-level test/debug logic and one `mem` instance, and muxes onto the memory port while `busy` is high.

## Interface
- `WIDTH`, 8, memory data word width
- `DEPTH`, 4, memory depth in words (power of two, ≥2)
- `clk` input 1 rising-edge clock for all logic
- `res` input 1 reset, synchronous, active-high
- `start` input 1 begin a test run; sampled only in IDLE or DONE
- `busy` output 1 test sequence running
- `done` output 1 run finished; held until next `start` or `res`
- `pass` output 1 valid when `done`=1: 1 means no mismatch
- `fail_addr` output $clog2(DEPTH) address of the first mismatch
- `fail_exp` output WIDTH expected data at the first mismatch
- `fail_got` output WIDTH read data at the first mismatch
- `mem_req` output 1 memory request, equal to `busy`
- `mem_wen` output 1 memory write enable
- `mem_ren` output 1 memory read enable
- `mem_size` output 2 constant 2'b01 (byte access)
- `mem_addr` output $clog2(DEPTH) memory address
- `mem_wr_data` output WIDTH memory write data
- `mem_rd_data` input WIDTH memory read data, valid the cycle after `mem_ren`

## Operation
- States: IDLE, WR, RD, CMP, CHK_RD, CHK_CMP, DONE.
- Step for target address i with pattern p: WR (`mem_wen`=1, addr i, data p), RD (`mem_ren`=1, addr i), CMP (compare `mem_rd_data` to p). Then full-array check: for a = 0..DEPTH-1, CHK_RD (`mem_ren`=1, addr a) followed by CHK_CMP (compare to E(a)).
- Phase 0, zeros: for i = 0..DEPTH-1, step(i, 0). One full check after the last i. E(a)=0.
- Phase 1, walking one: for each i, for j = 0..WIDTH-1, step(i, 1<<j) plus a full check. E(i)=1<<j, E(a≠i)=0. After j = WIDTH-1, a single WR cycle writes 0 to i.
- Phase 2, ones: for each i, step(i, all ones) plus a full check. E(a)=all ones for a ≤ i, else 0.
- Phase 3, logic: for each i, step(i, DEPTH-1-i, zero-extended to WIDTH) plus a full check. E(a)=DEPTH-1-a for a ≤ i, else all ones.
- E(a) is computed combinationally from phase, i, j and a. No shadow RAM.
- First mismatch in CMP or CHK_CMP latches `fail_addr`/`fail_exp`/`fail_got`, sets `pass`=0 and goes to DONE next cycle. The run stops on the first error.
- Completion without a mismatch: DONE with `pass`=1; `fail_*` stay 0.
- `start` while busy is ignored. `start` in DONE clears `done`, `pass` and `fail_*` and restarts from phase 0.

## Timing
- Reset values: every output is 0 except `mem_size`=2'b01. State is IDLE.
- `res` mid-run: on the next edge go to IDLE, drop `mem_wen`/`mem_ren`/`mem_req` and clear all status. No partial result is reported.
- `start` is sampled at edge k. From edge k the FSM is in WR with `busy`=1.
- `mem_wen` and `mem_ren` are each high for exactly one cycle per access and are never high together.
- Read compare happens one cycle after the `mem_ren` cycle.
- Cycles with `busy`=1 for a passing run: 3·DEPTH + 2·DEPTH + DEPTH·(WIDTH·(3 + 2·DEPTH) + 1) + 2·DEPTH·(3 + 2·DEPTH). For the defaults that is 20 + 356 + 44 + 44 = 464. `done`=1 on the following cycle.
- All outputs are registered.

## Test plan
- Good memory, defaults, reset, then `start` for 1 cycle: `busy` high for 464 cycles, then `done`=1, `pass`=1, `fail_addr`=0, `fail_exp`=0, `fail_got`=0.
- Memory model with bit 3 of address 2 stuck at 0: `done`, `pass`=0, `fail_addr`=2, `fail_exp`=8'h08, `fail_got`=8'h00. This is the phase-1 step compare, reached 20 + 2·89 + 3·11 + 3 = 234 cycles after `start`.
- Address alias (a write to 1 also writes 3): fails in the phase-1 full check for i=1, j=0, with `fail_addr`=3, `fail_exp`=0, `fail_got`=8'h01.
- Run a passing test, pulse `res` 100 cycles into a second run: the next cycle shows all outputs at reset values. A following `start` completes with `pass`=1 after 464 cycles.
- Hold `start` high throughout a run: there is no restart mid-run; `done` after 464 cycles. With `start` still high in DONE, a new run begins on the next edge with `done` cleared.
- Protocol monitor for every cycle of a full run: `mem_wen`&`mem_ren` never both 1, `mem_req`==`busy`, `mem_size`==2'b01, and `mem_addr` < DEPTH.

Source files
------------

// File: rtl/mem_bist.sv
// mem_bist: built-in self-test controller for one `mem` instance.
//
// After `start` it runs four pattern phases against the memory: zeros,
// walking one, ones, and an address-derived "logic" pattern. Each target
// address goes through one step (write, read, compare). A full-array
// read-back check follows every step, except in the zeros phase, which is
// checked once after its last step. Expected data is computed from
// (phase, target, bit, address), so no shadow copy of the memory is kept.
// The run stops on the first mismatch and latches it.
//
// Ports:
//   clk, res      rising-edge clock, synchronous active-high reset
//   start         begin a run (sampled only in IDLE or DONE)
//   busy, done    run in progress / run finished (held)
//   pass          valid with done: 1 = no mismatch seen
//   fail_addr/exp/got  address, expected and read data of the first mismatch
//   mem_*         initiator side of the memory write/read interface
module mem_bist #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [$clog2(DEPTH)-1:0] fail_addr,
    output logic [WIDTH-1:0]         fail_exp,
    output logic [WIDTH-1:0]         fail_got,
    output logic                     mem_req,
    output logic                     mem_wen,
    output logic                     mem_ren,
    output logic [1:0]               mem_size,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [WIDTH-1:0]         mem_wr_data,
    input  logic [WIDTH-1:0]         mem_rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [JW-1:0] LAST_BIT  = JW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, WR, RD, CMP, CHK_RD, CHK_CMP, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [AW-1:0]     idx_q, idx_d;     // target address i
    logic [JW-1:0]     bit_q, bit_d;     // walking-one position j
    logic [AW-1:0]     chk_q, chk_d;     // full-check address a
    logic              clr_q, clr_d;     // pending walking-one clear write

    logic              pass_d;
    logic [AW-1:0]     fail_addr_d;
    logic [WIDTH-1:0]  fail_exp_d, fail_got_d;
    logic              busy_d, done_d, wen_d, ren_d;
    logic [AW-1:0]     addr_d;
    logic [WIDTH-1:0]  wdata_d;

    logic [WIDTH-1:0]  cmp_exp;
    logic [AW-1:0]     cmp_addr;
    logic              mismatch;

    // Expected content of address a while testing target i with bit j.
    // The step pattern written to i is expected_word(ph, i, j, i).
    function automatic logic [WIDTH-1:0] expected_word(
        input logic [1:0]    ph,
        input logic [AW-1:0] ti,
        input logic [JW-1:0] tj,
        input logic [AW-1:0] ta
    );
        case (ph)
            2'd0:    return '0;
            2'd1:    return (ta == ti) ? (WIDTH'(1) << tj) : '0;
            2'd2:    return (ta <= ti) ? '1 : '0;
            default: return (ta <= ti) ? WIDTH'(DEPTH - 1 - int'(ta)) : '1;
        endcase
    endfunction

    assign mem_size = 2'b01;
    assign mem_req  = busy;

    // NOTE: every variable driven here gets a default first so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        bit_d       = bit_q;
        chk_d       = chk_q;
        clr_d       = clr_q;
        pass_d      = pass;
        fail_addr_d = fail_addr;
        fail_exp_d  = fail_exp;
        fail_got_d  = fail_got;

        cmp_addr = (state_q == CHK_CMP) ? chk_q : idx_q;
        cmp_exp  = expected_word(phase_q, idx_q, bit_q, cmp_addr);
        mismatch = (state_q inside {CMP, CHK_CMP}) && (mem_rd_data != cmp_exp);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = WR;
                    phase_d     = 2'd0;
                    idx_d       = '0;
                    bit_d       = '0;
                    chk_d       = '0;
                    clr_d       = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_got_d  = '0;
                end
            end
            WR: begin
                if (clr_q) begin
                    // Clear write ends the walking-one run for this target;
                    // it is not read back by a step compare.
                    clr_d = 1'b0;
                    if (idx_q == LAST_ADDR) begin
                        phase_d = 2'd2;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end else begin
                    state_d = RD;
                end
            end
            RD:     state_d = CMP;
            CMP: begin
                if (phase_q == 2'd0 && idx_q != LAST_ADDR) begin
                    // Zeros phase checks the array only once, at the end.
                    idx_d   = idx_q + AW'(1);
                    state_d = WR;
                end else begin
                    chk_d   = '0;
                    state_d = CHK_RD;
                end
            end
            CHK_RD: state_d = CHK_CMP;
            CHK_CMP: begin
                if (chk_q != LAST_ADDR) begin
                    chk_d   = chk_q + AW'(1);
                    state_d = CHK_RD;
                end else begin
                    state_d = WR;
                    case (phase_q)
                        2'd0: begin
                            phase_d = 2'd1;
                            idx_d   = '0;
                            bit_d   = '0;
                        end
                        2'd1: begin
                            if (bit_q == LAST_BIT) begin
                                bit_d = '0;
                                clr_d = 1'b1;
                            end else begin
                                bit_d = bit_q + JW'(1);
                            end
                        end
                        2'd2: begin
                            if (idx_q == LAST_ADDR) begin
                                phase_d = 2'd3;
                                idx_d   = '0;
                            end else begin
                                idx_d = idx_q + AW'(1);
                            end
                        end
                        default: begin
                            if (idx_q == LAST_ADDR) begin
                                state_d = DONE;
                                pass_d  = 1'b1;
                            end else begin
                                idx_d = idx_q + AW'(1);
                            end
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        // First mismatch wins over any normal progression.
        if (mismatch) begin
            state_d     = DONE;
            pass_d      = 1'b0;
            fail_addr_d = cmp_addr;
            fail_exp_d  = cmp_exp;
            fail_got_d  = mem_rd_data;
        end

        // Outputs are registered from the next-state view so that they line
        // up with the state they describe.
        busy_d  = !(state_d inside {IDLE, DONE});
        done_d  = (state_d == DONE);
        wen_d   = (state_d == WR);
        ren_d   = (state_d inside {RD, CHK_RD});
        addr_d  = (state_d == CHK_RD) ? chk_d : idx_d;
        wdata_d = (state_d == WR && !clr_d) ? expected_word(phase_d, idx_d, bit_d, idx_d) : '0;
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= IDLE;
            phase_q     <= 2'd0;
            idx_q       <= '0;
            bit_q       <= '0;
            chk_q       <= '0;
            clr_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            fail_exp    <= '0;
            fail_got    <= '0;
            mem_wen     <= 1'b0;
            mem_ren     <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            bit_q       <= bit_d;
            chk_q       <= chk_d;
            clr_q       <= clr_d;
            busy        <= busy_d;
            done        <= done_d;
            pass        <= pass_d;
            fail_addr   <= fail_addr_d;
            fail_exp    <= fail_exp_d;
            fail_got    <= fail_got_d;
            mem_wen     <= wen_d;
            mem_ren     <= ren_d;
            mem_addr    <= addr_d;
            mem_wr_data <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_bist.sv
// Testbench for mem_bist: a memory model with configurable faults (none,
// single stuck bit, write alias), and a behavioural predictor that walks the
// four test phases with plain loops. The predictor yields the expected access
// trace, run length and failure record, and a per-cycle monitor checks the
// memory port against that trace.
module tb_mem_bist;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AW = $clog2(D);

    logic          clk = 1'b0;
    logic          res;
    logic          start;
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [W-1:0]  fail_exp, fail_got;
    logic          mem_req, mem_wen, mem_ren;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wr_data;
    logic [W-1:0]  mem_rd_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_bist #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_exp   (fail_exp),
        .fail_got   (fail_got),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- fault configuration and memory model ----------------
    int fault_kind = 0;   // 0 none, 1 stuck bit, 2 write alias
    int f_addr = 0, f_bit = 0, alias_src = 0, alias_dst = 0;
    bit f_val = 1'b0;

    function automatic logic [W-1:0] apply_stuck(input logic [W-1:0] v, input int a);
        logic [W-1:0] r = v;
        if (fault_kind == 1 && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    logic [W-1:0] dmem [D];

    always @(posedge clk) begin
        if (mem_wen) begin
            dmem[mem_addr] <= mem_wr_data;
            if (fault_kind == 2 && int'(mem_addr) == alias_src) dmem[alias_dst] <= mem_wr_data;
        end
        if (mem_ren) mem_rd_data <= apply_stuck(dmem[mem_addr], int'(mem_addr));
    end

    // ---------------- behavioural predictor ----------------
    typedef struct {
        bit           wen;
        bit           ren;
        int           addr;
        logic [W-1:0] data;
    } op_t;

    op_t          exp_ops[$];
    logic [W-1:0] ref_mem [D];   // faulty memory as it really behaves
    logic [W-1:0] ideal   [D];   // what a good memory would hold
    int           p_cycles;
    bit           p_ok;
    int           p_addr;
    logic [W-1:0] p_exp, p_got;

    function automatic void p_write(input int a, input logic [W-1:0] d);
        if (!p_ok) return;
        p_cycles++;
        exp_ops.push_back('{1'b1, 1'b0, a, d});
        ref_mem[a] = d;
        if (fault_kind == 2 && a == alias_src) ref_mem[alias_dst] = d;
        ideal[a] = d;
    endfunction

    // Read cycle plus compare cycle against the ideal content.
    function automatic void p_read(input int a);
        logic [W-1:0] got;
        if (!p_ok) return;
        p_cycles += 2;
        exp_ops.push_back('{1'b0, 1'b1, a, '0});
        exp_ops.push_back('{1'b0, 1'b0, 0, '0});
        got = apply_stuck(ref_mem[a], a);
        if (got !== ideal[a]) begin
            p_ok   = 1'b0;
            p_addr = a;
            p_exp  = ideal[a];
            p_got  = got;
        end
    endfunction

    function automatic void p_check_all();
        for (int a = 0; a < D; a++) p_read(a);
    endfunction

    function automatic void predict();
        p_ok = 1'b1; p_cycles = 0; p_addr = 0; p_exp = '0; p_got = '0;
        exp_ops.delete();
        for (int a = 0; a < D; a++) begin ref_mem[a] = '0; ideal[a] = '0; end
        for (int i = 0; i < D; i++) begin p_write(i, '0); p_read(i); end
        p_check_all();
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < W; j++) begin
                p_write(i, W'(1) << j); p_read(i); p_check_all();
            end
            p_write(i, '0);
        end
        for (int i = 0; i < D; i++) begin p_write(i, '1); p_read(i); p_check_all(); end
        for (int i = 0; i < D; i++) begin
            p_write(i, W'(D - 1 - i)); p_read(i); p_check_all();
        end
    endfunction

    // ---------------- protocol / trace monitor ----------------
    bit  mon_en = 1'b0;
    op_t mon_op;

    always @(negedge clk) begin
        if (mon_en && !res) begin
            check("wen_ren_excl", mem_wen & mem_ren, 0);
            check("req_eq_busy", mem_req, busy);
            check("mem_size", mem_size, 2'b01);
            check("addr_range", int'(mem_addr) < D, 1);
            if (busy) begin
                if (exp_ops.size() == 0) begin
                    check("op_underflow", 1, 0);
                end else begin
                    mon_op = exp_ops.pop_front();
                    check("op_wen", mem_wen, mon_op.wen);
                    check("op_ren", mem_ren, mon_op.ren);
                    if (mon_op.wen || mon_op.ren) check("op_addr", mem_addr, mon_op.addr);
                    if (mon_op.wen) check("op_data", mem_wr_data, mon_op.data);
                end
            end
        end
    end

    // ---------------- run helpers ----------------
    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_faddr"}, fail_addr, 0);
        check({tag, "_fexp"}, fail_exp, 0);
        check({tag, "_fgot"}, fail_got, 0);
        check({tag, "_req"}, mem_req, 0);
        check({tag, "_wen"}, mem_wen, 0);
        check({tag, "_ren"}, mem_ren, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wr_data, 0);
        check({tag, "_size"}, mem_size, 2'b01);
    endtask

    // Called #1 after the edge that accepted start; waits for done.
    task automatic finish_run(input string tag, output int lat);
        int bc = 0;
        lat = 0;
        while (!done && lat < 3000) begin
            if (busy) bc++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_latency"}, lat, p_cycles);
        check({tag, "_busy_cycles"}, bc, p_cycles);
        check({tag, "_pass"}, pass, p_ok);
        check({tag, "_fail_addr"}, fail_addr, p_addr);
        check({tag, "_fail_exp"}, fail_exp, p_exp);
        check({tag, "_fail_got"}, fail_got, p_got);
        check({tag, "_ops_left"}, exp_ops.size(), 0);
    endtask

    task automatic launch(input string tag, input bit hold);
        predict();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        check({tag, "_busy_at_k"}, busy, 1);
        check({tag, "_done_clr"}, done, 0);
        check({tag, "_pass_clr"}, pass, 0);
        check({tag, "_fgot_clr"}, fail_got, 0);
    endtask

    task automatic run_test(input string tag, output int lat);
        launch(tag, 1'b0);
        finish_run(tag, lat);
    endtask

    int lat;

    initial begin
        res = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        res = 1'b0;
        mon_en = 1'b1;

        // Good memory, defaults.
        fault_kind = 0;
        run_test("good", lat);
        check("good_464", lat, 464);
        check("good_pass_const", pass, 1);

        // Bit 3 of address 2 stuck at 0.
        fault_kind = 1; f_addr = 2; f_bit = 3; f_val = 1'b0;
        run_test("stuck", lat);
        check("stuck_234", lat, 234);
        check("stuck_addr_const", fail_addr, 2);
        check("stuck_exp_const", fail_exp, 8'h08);
        check("stuck_got_const", fail_got, 8'h00);

        // Write to 1 also writes 3.
        fault_kind = 2; alias_src = 1; alias_dst = 3;
        run_test("alias", lat);
        check("alias_addr_const", fail_addr, 3);
        check("alias_exp_const", fail_exp, 8'h00);
        check("alias_got_const", fail_got, 8'h01);

        // Passing run, then reset 100 cycles into a second run.
        fault_kind = 0;
        run_test("pre_res", lat);
        launch("midres", 1'b0);
        repeat (100) begin @(posedge clk); #1; end
        res = 1'b1;
        @(posedge clk); #1;
        check_reset("midres");
        res = 1'b0;
        exp_ops.delete();
        run_test("post_res", lat);
        check("post_res_464", lat, 464);

        // Start held high for a whole run, then restart from DONE.
        launch("hold", 1'b1);
        finish_run("hold", lat);
        check("hold_464", lat, 464);
        predict();
        @(posedge clk); #1;
        check("hold_restart_done", done, 0);
        check("hold_restart_busy", busy, 1);
        start = 1'b0;
        finish_run("hold2", lat);

        // Randomized fault configurations.
        for (int k = 0; k < 8; k++) begin
            fault_kind = int'($urandom_range(0, 2));
            f_addr     = int'($urandom_range(0, D - 1));
            f_bit      = int'($urandom_range(0, W - 1));
            f_val      = 1'($urandom_range(0, 1));
            alias_src  = int'($urandom_range(0, D - 1));
            alias_dst  = (alias_src + int'($urandom_range(1, D - 1))) % D;
            run_test($sformatf("rand%0d", k), lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
